// File: rtl/elevator_pkg.sv
// Shared defaults and width helper for the elevator call-handling blocks.
package elevator_pkg;

    localparam int FLOORS_DEFAULT   = 8;
    localparam int DEBOUNCE_DEFAULT = 4;

    // Bits needed to encode n distinct values (at least 1).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stable-level debouncer and a one-cycle
// pulse on each accepted rising edge of the stable level.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic a_reset,
    input  logic raw,
    output logic rise
);

    localparam int CW = 8;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          hit;

    assign differ = (sync2 != stable);
    assign hit    = differ && (cnt == CW'(DEBOUNCE - 1));

    // NOTE: state uses non-blocking assignments and an async reset so every
    // flop clears the moment a_reset rises, discarding any partial count.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!differ || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (hit) begin
                stable <= ~stable;
            end
            rise <= hit && !stable;
        end
    end

endmodule

// File: rtl/call_register.sv
// Latches debounced cab and hall calls, clears them on service, and reports
// where outstanding calls lie relative to the cab.
module call_register
    import elevator_pkg::*;
#(
    parameter  int FLOORS   = FLOORS_DEFAULT,
    parameter  int DEBOUNCE = DEBOUNCE_DEFAULT,
    localparam int FLOOR_W  = clog2(FLOORS),
    localparam int CNT_W    = clog2(3 * FLOORS - 1)
) (
    input  logic               clk,
    input  logic               a_reset,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-2:0]  btn_up,
    input  logic [FLOORS-2:0]  btn_down,
    input  logic [FLOORS-1:0]  clr_in,
    input  logic [FLOORS-2:0]  clr_up,
    input  logic [FLOORS-2:0]  clr_down,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  active_in,
    output logic [FLOORS-2:0]  active_up,
    output logic [FLOORS-2:0]  active_down,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here,
    output logic [CNT_W-1:0]   pending_cnt
);

    localparam int NB = 3 * FLOORS - 2;

    // Flat layout: {down, up, in}, matching on raw, clear and active vectors.
    logic [NB-1:0]     raw;
    logic [NB-1:0]     clr;
    logic [NB-1:0]     rise;
    logic [NB-1:0]     active;
    logic [FLOORS-1:0] floor_req;

    assign raw = {btn_down, btn_up, btn_in};
    assign clr = {clr_down, clr_up, clr_in};

    for (genvar b = 0; b < NB; b++) begin : g_btn
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk     (clk),
            .a_reset (a_reset),
            .raw     (raw[b]),
            .rise    (rise[b])
        );
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            active <= '0;
        end else begin
            active <= (active & ~clr) | rise;
        end
    end

    assign active_in   = active[FLOORS-1:0];
    assign active_up   = active[2*FLOORS-2:FLOORS];
    assign active_down = active[NB-1:2*FLOORS-1];

    // Up call j sits at floor j, down call j at floor j+1.
    assign floor_req = active_in | {1'b0, active_up} | {active_down, 1'b0};

    // NOTE: every combinational output gets a default before the loop so no
    // latch is inferred.
    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        req_here  = 1'b0;
        if (int'(cur_floor) < FLOORS) begin
            for (int f = 0; f < FLOORS; f++) begin
                if (f > int'(cur_floor)) begin
                    req_above = req_above | floor_req[f];
                end else if (f < int'(cur_floor)) begin
                    req_below = req_below | floor_req[f];
                end else begin
                    req_here = req_here | floor_req[f];
                end
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int b = 0; b < NB; b++) begin
            pending_cnt = pending_cnt + CNT_W'(active[b]);
        end
    end

endmodule
